// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: game states, move directions and button indices.
// Imported by the sequencer, the button front end and gamelogic.
package snake_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WON  = 2'd2,
      ST_LOST = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_t;

   // Button vector bit i carries the button whose direction code is i.
   localparam int BTN_N = 4;

   // Left/right and up/down differ only in bit 0.
   function automatic dir_t dir_opposite(input dir_t d);
      return dir_t'(d ^ 2'b01);
   endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer plus registered rising-edge detect for the four raw buttons.
// press[i] is high for exactly one cycle, three cycles after button i first reads high.
module button_sync
   import snake_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [BTN_N-1:0] btn,
   output logic [BTN_N-1:0] press
);

   logic [BTN_N-1:0] sync_p0;
   logic [BTN_N-1:0] sync_p1;
   logic [BTN_N-1:0] prev_p2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         prev_p2 <= '0;
         press   <= '0;
      end else begin
         sync_p0 <= btn;
         // metastability settles between p0 and p1; edge detect compares p1 with its delayed copy
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
         press   <= sync_p1 & ~prev_p2;
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Snake game sequencer: game FSM, score-scaled move-tick generator and direction latch
// feeding gamelogic with step, direction and a one-cycle game_rst on every new game.
module game_sequencer
   import snake_pkg::*;
#(
   parameter int TICK_BASE  = 6250000,
   parameter int TICK_DEC   = 500000,
   parameter int LEVELS     = 8,
   parameter int LEVEL_STEP = 3,
   parameter int SCORE_W    = 5
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               btnu,
   input  logic               btnd,
   input  logic               btnl,
   input  logic               btnr,
   input  logic [SCORE_W-1:0] score,
   input  logic               won,
   input  logic               lost,
   output logic               step,
   output logic [1:0]         direction,
   output logic [1:0]         game_state,
   output logic               game_rst,
   output logic [2:0]         level
);

   logic [BTN_N-1:0] press;
   logic             any_press;
   state_t           state_q;
   state_t           state_d;
   logic             start;
   logic [31:0]      tick_cnt;
   logic [31:0]      period;
   logic             tick_wrap;
   logic             level_up;
   logic [2:0]       level_q;
   dir_t             dir_q;
   dir_t             next_dir_q;
   dir_t             req_dir;
   logic             req_vld;

   button_sync u_button_sync (
      .clk   (clk),
      .rst   (rst),
      .btn   ({btnd, btnu, btnr, btnl}),
      .press (press)
   );

   assign any_press = |press;
   assign period    = 32'(TICK_BASE) - 32'(level_q) * 32'(TICK_DEC);
   assign tick_wrap = (state_q == ST_PLAY) && (tick_cnt >= period - 32'd1);
   assign level_up  = (32'(level_q) < 32'(LEVELS - 1)) &&
                      (32'(score) >= (32'(level_q) + 32'd1) * 32'(LEVEL_STEP));

   // Right beats left beats up beats down. A request that would reverse either the
   // committed or the already-pending direction is dropped.
   always_comb begin
      req_dir = DIR_DOWN;
      if (press[DIR_RIGHT])
         req_dir = DIR_RIGHT;
      else if (press[DIR_LEFT])
         req_dir = DIR_LEFT;
      else if (press[DIR_UP])
         req_dir = DIR_UP;
      req_vld = (state_q == ST_PLAY) && any_press &&
                (req_dir != dir_opposite(dir_q)) &&
                (req_dir != dir_opposite(next_dir_q));
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_press) begin
               state_d = ST_PLAY;
               start   = 1'b1;
            end
         end
         ST_PLAY: begin
            if (won)
               state_d = ST_WON;
            else if (lost)
               state_d = ST_LOST;
         end
         ST_WON, ST_LOST: begin
            if (any_press)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt   <= '0;
         step       <= 1'b0;
         game_rst   <= 1'b0;
         level_q    <= '0;
         dir_q      <= DIR_RIGHT;
         next_dir_q <= DIR_RIGHT;
      end else begin
         step     <= 1'b0;
         game_rst <= start;
         if (start) begin
            tick_cnt   <= '0;
            level_q    <= '0;
            dir_q      <= DIR_RIGHT;
            next_dir_q <= DIR_RIGHT;
         end else if (state_q == ST_PLAY) begin
            // direction and level commit on the same edge that raises step
            if (tick_wrap) begin
               tick_cnt <= '0;
               step     <= 1'b1;
               dir_q    <= next_dir_q;
               if (level_up)
                  level_q <= level_q + 3'd1;
            end else begin
               tick_cnt <= tick_cnt + 32'd1;
            end
            if (req_vld)
               next_dir_q <= req_dir;
         end
      end
   end

   assign direction  = dir_q;
   assign game_state = state_q;
   assign level      = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios then random play, all outputs
// compared every cycle against a move-schedule model of the game rules.
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] b;
   logic [4:0] score;
   logic       won;
   logic       lost;
   logic       step;
   logic [1:0] direction;
   logic [1:0] game_state;
   logic       game_rst;
   logic [2:0] level;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   game_sequencer #(
      .TICK_BASE  (20),
      .TICK_DEC   (4),
      .LEVELS     (4),
      .LEVEL_STEP (2),
      .SCORE_W    (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btnu       (b[2]),
      .btnd       (b[3]),
      .btnl       (b[0]),
      .btnr       (b[1]),
      .score      (score),
      .won        (won),
      .lost       (lost),
      .step       (step),
      .direction  (direction),
      .game_state (game_state),
      .game_rst   (game_rst),
      .level      (level)
   );

   // Reference: states 0 idle 1 play 2 won 3 lost; directions 0 l 1 r 2 u 3 d.
   // Moves are scheduled as absolute edge numbers rather than counted down.
   longint     cyc = 0;
   longint     m_due = 0;
   int         m_state, m_dir, m_next, m_level;
   int         m_step, m_grst;
   logic [3:0] m_press, h1, h2, h3;

   function automatic int period_of(input int lv);
      return 20 - lv * 4;
   endfunction

   task automatic model_edge();
      logic [3:0] np;
      int         req, old_dir, old_next;
      cyc++;
      if (rst) begin
         m_state = 0; m_dir = 1; m_next = 1; m_level = 0;
         m_step = 0; m_grst = 0;
         m_press = '0; h1 = '0; h2 = '0; h3 = '0;
         return;
      end
      // a press shows up three edges after the button is first sampled high
      np = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = b;
      m_step = 0;
      m_grst = 0;
      old_dir = m_dir;
      old_next = m_next;
      case (m_state)
         0: begin
            if (m_press != 0) begin
               m_state = 1; m_grst = 1; m_dir = 1; m_next = 1; m_level = 0;
               m_due = cyc + period_of(0);
            end
         end
         1: begin
            if (cyc == m_due) begin
               m_step = 1;
               m_dir = old_next;
               if (m_level < 3 && int'(score) >= (m_level + 1) * 2) m_level++;
               m_due = cyc + period_of(m_level);
            end
            if (m_press != 0) begin
               req = m_press[1] ? 1 : m_press[0] ? 0 : m_press[2] ? 2 : 3;
               if (req != (old_dir ^ 1) && req != (old_next ^ 1)) m_next = req;
            end
            if (won) m_state = 2;
            else if (lost) m_state = 3;
         end
         default: begin
            if (m_press != 0) m_state = 0;
         end
      endcase
      m_press = np;
   endtask

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("step", int'(step), m_step);
      check("direction", int'(direction), m_dir);
      check("game_state", int'(game_state), m_state);
      check("game_rst", int'(game_rst), m_grst);
      check("level", int'(level), m_level);
   endtask

   task automatic press_btn(input logic [3:0] v);
      b = v;
      cycle();
      b = '0;
   endtask

   task automatic wait_step(input int limit, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (step !== 1'b1 && n < limit);
      check("step_seen", int'(step), 1);
   endtask

   initial begin
      int n;
      int nsteps;
      rst = 1'b1; b = '0; score = '0; won = 1'b0; lost = 1'b0;
      repeat (3) cycle();
      rst = 1'b0;
      check("rst_state", int'(game_state), 0);
      check("rst_dir", int'(direction), 1);
      check("rst_level", int'(level), 0);
      check("rst_step", int'(step), 0);

      // start: press lands on edge 3, PLAY from edge 4
      press_btn(4'b0100);
      repeat (3) cycle();
      check("start_state", int'(game_state), 1);
      check("start_grst", int'(game_rst), 1);
      cycle();
      check("grst_once", int'(game_rst), 0);
      repeat (18) cycle();
      check("pre_first_step", int'(step), 0);
      cycle();
      check("first_step", int'(step), 1);
      wait_step(40, n);
      check("period_l0", n, 20);

      // reversal rejection
      press_btn(4'b0001);
      wait_step(40, n);
      check("rev_left_dir", int'(direction), 1);
      press_btn(4'b0100);
      cycle();
      press_btn(4'b1000);
      wait_step(40, n);
      check("up_then_down_dir", int'(direction), 2);

      // simultaneous right and up while heading up
      press_btn(4'b0110);
      wait_step(40, n);
      check("simul_dir", int'(direction), 1);

      // speed-up and saturation
      score = 5'd2;
      wait_step(40, n);
      check("lvl1", int'(level), 1);
      wait_step(40, n);
      check("period_l1", n, 16);
      check("lvl1_hold", int'(level), 1);
      score = 5'd6;
      wait_step(40, n);
      check("lvl2", int'(level), 2);
      wait_step(40, n);
      check("period_l2", n, 12);
      check("lvl3", int'(level), 3);
      wait_step(40, n);
      check("period_l3", n, 8);
      score = 5'd31;
      wait_step(40, n);
      check("lvl_sat", int'(level), 3);

      // won and lost together: won wins, play freezes
      won = 1'b1; lost = 1'b1;
      cycle();
      won = 1'b0; lost = 1'b0;
      check("won_state", int'(game_state), 2);
      nsteps = 0;
      repeat (30) begin
         cycle();
         if (step === 1'b1) nsteps++;
      end
      check("won_nostep", nsteps, 0);
      press_btn(4'b0010);
      repeat (3) cycle();
      check("back_idle", int'(game_state), 0);
      check("idle_step", int'(step), 0);
      score = '0;
      press_btn(4'b1000);
      repeat (3) cycle();
      check("replay_state", int'(game_state), 1);
      check("replay_grst", int'(game_rst), 1);
      check("replay_dir", int'(direction), 1);
      check("replay_level", int'(level), 0);

      // reset mid-count
      repeat (7) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("mid_rst_state", int'(game_state), 0);
      check("mid_rst_step", int'(step), 0);
      check("mid_rst_dir", int'(direction), 1);
      check("mid_rst_level", int'(level), 0);
      check("mid_rst_grst", int'(game_rst), 0);

      // random play
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) b = 4'($urandom_range(0, 15));
         else if ($urandom_range(0, 2) == 0) b = '0;
         if ($urandom_range(0, 49) == 0) score = 5'($urandom_range(0, 31));
         won  = ($urandom_range(0, 299) == 0);
         lost = ($urandom_range(0, 299) == 0);
         rst  = ($urandom_range(0, 599) == 0);
         cycle();
      end
      rst = 1'b0; won = 1'b0; lost = 1'b0; b = '0;
      repeat (5) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
